// File: rtl/fifo_readout_pkg.sv
// Shared types and header layout for the FIFO frame readout sequencer.
package fifo_readout_pkg;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2,
    PAD     = 2'd3
  } state_t;

  // Header word: [15:12] tag, [11] overflow, [10:8] zero, [7:0] sequence.
  localparam logic [3:0]  HDR_TAG     = 4'hA;
  localparam logic [15:0] PAD_WORD    = 16'h0000;
  localparam int          HDR_TAG_LSB = 12;
  localparam int          HDR_TAG_W   = 4;
  localparam int          HDR_OVF_BIT = 11;
  localparam int          HDR_SEQ_LSB = 0;
  localparam int          HDR_SEQ_W   = 8;

  // Assemble a header word from the overflow flag and the sequence number.
  function automatic logic [15:0] make_header(input logic ovf, input logic [HDR_SEQ_W-1:0] seq);
    logic [15:0] h;
    h = '0;
    h[HDR_TAG_LSB +: HDR_TAG_W] = HDR_TAG;
    h[HDR_OVF_BIT]              = ovf;
    h[HDR_SEQ_LSB +: HDR_SEQ_W] = seq;
    return h;
  endfunction

endpackage

// File: rtl/fifo_prefetch2.sv
// Two-entry prefetch buffer between the FIFO read port and the frame stream.
// The head of the buffer is always slot0; push and pop may happen together.
module fifo_prefetch2 (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [15:0] din,
  input  logic        pop,
  output logic [15:0] head,
  output logic [1:0]  occ
);

  logic [15:0] slot0;
  logic [15:0] slot1;
  logic        pop_ok;
  logic        push_ok;

  // A pop on an empty buffer is ignored; a push into a full buffer is only
  // accepted when a pop frees a slot in the same cycle.
  always_comb begin
    pop_ok  = pop & (occ != 2'd0);
    push_ok = push & ((occ != 2'd2) | pop_ok);
  end

  // Shift-down storage: a pop moves slot1 into slot0, a push fills the first free slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot0 <= '0;
      slot1 <= '0;
      occ   <= 2'd0;
    end else begin
      case ({push_ok, pop_ok})
        2'b11: begin
          if (occ == 2'd1) begin
            slot0 <= din;
          end else begin
            slot0 <= slot1;
            slot1 <= din;
          end
        end
        2'b10: begin
          if (occ == 2'd0) begin
            slot0 <= din;
          end else begin
            slot1 <= din;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          occ   <= occ - 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign head = slot0;

endmodule

// File: rtl/fifo_frame_readout_ctrl.sv
// Read-side frame sequencer: drains the acquisition FIFO through a 2-entry
// prefetch buffer and emits header + fixed-length payload frames on a
// valid/ready stream, padding frames that stall on flush or timeout.
module fifo_frame_readout_ctrl
  import fifo_readout_pkg::*;
#(
  parameter int FRAME_WORDS = 64,
  parameter int SEQ_W       = 8,
  parameter int TIMEOUT     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        flush,
  input  logic        clr_ovf,
  input  logic        fifo_empty,
  input  logic        fifo_full,
  input  logic [15:0] fifo_dout,
  output logic        fifo_rd_en,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sof,
  output logic        out_eof,
  output logic        busy,
  output logic        ovf_sticky,
  output logic [15:0] frame_count
);

  localparam int                CNT_W     = $clog2(FRAME_WORDS);
  localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(FRAME_WORDS - 1);
  localparam int                TMR_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TMR_W-1:0]  TMR_MAX   = TMR_W'(TIMEOUT);

  state_t           state;
  logic [CNT_W-1:0] word_cnt;
  logic [TMR_W-1:0] starve;
  logic [SEQ_W-1:0] seq;
  logic             inflight;
  logic             flush_pending;
  logic             frame_ovf;
  logic             hdr_ovf;
  logic [1:0]       occ;
  logic [15:0]      head;
  logic             run;
  logic             xfer;
  logic             pop;
  logic             last_word;
  logic             timeout_hit;
  logic             frame_done;

  fifo_prefetch2 u_prefetch (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .din  (fifo_dout),
    .pop  (pop),
    .head (head),
    .occ  (occ)
  );

  // Read strobes are issued only while there is room for the word once it
  // lands; reset gates the strobe so nothing is requested while held in reset.
  always_comb begin
    busy        = (state != IDLE);
    run         = enable | busy;
    fifo_rd_en  = rst & run & ~fifo_empty & (({1'b0, occ} + {2'b00, inflight}) < 3'd2);
    last_word   = (word_cnt == LAST_WORD);
    timeout_hit = (TIMEOUT != 0) && (starve == TMR_MAX);
  end

  // Stream outputs are decoded purely from registered state and buffer
  // occupancy, so they stay stable while a word waits for out_ready.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_sof   = 1'b0;
    out_eof   = 1'b0;
    case (state)
      HDR: begin
        out_valid = 1'b1;
        out_sof   = 1'b1;
        out_data  = make_header(hdr_ovf, HDR_SEQ_W'(seq));
      end
      PAYLOAD: begin
        out_valid = (occ != 2'd0);
        out_data  = head;
        out_eof   = last_word;
      end
      PAD: begin
        out_valid = 1'b1;
        out_data  = PAD_WORD;
        out_eof   = last_word;
      end
      default: ;
    endcase
  end

  // Handshake qualifiers; only real payload words leave the buffer.
  always_comb begin
    xfer       = out_valid & out_ready;
    pop        = xfer & (state == PAYLOAD);
    frame_done = xfer & last_word & ((state == PAYLOAD) | (state == PAD));
  end

  // A FIFO word requested this cycle arrives on fifo_dout next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end

  // Frame sequencer: header, payload words with starve tracking, padding.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      word_cnt    <= '0;
      starve      <= '0;
      seq         <= '0;
      frame_count <= '0;
      hdr_ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && (occ != 2'd0)) begin
            state   <= HDR;
            hdr_ovf <= frame_ovf | fifo_full;
          end
        end
        HDR: begin
          if (xfer) begin
            state    <= PAYLOAD;
            word_cnt <= '0;
            starve   <= '0;
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            starve <= '0;
            if (last_word) begin
              state       <= IDLE;
              seq         <= seq + 1'b1;
              frame_count <= frame_count + 16'd1;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end else if (occ == 2'd0) begin
            if (flush_pending || timeout_hit) begin
              state <= PAD;
            end else if ((TIMEOUT != 0) && (starve != TMR_MAX)) begin
              starve <= starve + 1'b1;
            end
          end
        end
        PAD: begin
          if (xfer) begin
            if (last_word) begin
              state       <= IDLE;
              seq         <= seq + 1'b1;
              frame_count <= frame_count + 16'd1;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Flush request is remembered until the frame it targets has closed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_pending <= 1'b0;
    end else if (frame_done) begin
      flush_pending <= 1'b0;
    end else if (flush && ((state == HDR) || (state == PAYLOAD))) begin
      flush_pending <= 1'b1;
    end
  end

  // Overflow flags: a FIFO-full sighting beats any clear in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_sticky <= 1'b0;
      frame_ovf  <= 1'b0;
    end else begin
      if (fifo_full) begin
        ovf_sticky <= 1'b1;
      end else if (clr_ovf) begin
        ovf_sticky <= 1'b0;
      end
      if (fifo_full) begin
        frame_ovf <= 1'b1;
      end else if ((state == HDR) && xfer) begin
        frame_ovf <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fifo_frame_readout_ctrl.md
Name: fifo_frame_readout_ctrl

Overview:
- Read-side sequencer for the 1-bit→16-bit acquisition FIFO chain. Runs in the FIFO read clock domain.
- Drains 16-bit words from the FIFO through a 2-entry prefetch buffer and emits fixed-length frames on a valid/ready stream toward the host pipe.
- Each frame is one header word (sequence number, overflow flag) followed by FRAME_WORDS payload words.
- Frames that stall are padded out on flush request or timeout.

Parameters:
- FRAME_WORDS, 64: payload words per frame (≥2).
- SEQ_W, 8: sequence counter width (fixed at 8 by the header format).
- TIMEOUT, 1024: consecutive starved cycles in PAYLOAD before padding starts. 0 disables the timeout.

Ports:
- clk  in  1  read-domain clock (same clock as the FIFO read port).
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  permits new frames and prefetch.
- flush  in  1  single-cycle pulse: close the current frame with padding.
- clr_ovf  in  1  clears ovf_sticky.
- fifo_empty  in  1  FIFO empty flag.
- fifo_full  in  1  FIFO full flag, already synchronized to clk upstream.
- fifo_dout  in  16  FIFO read data, valid 1 cycle after fifo_rd_en.
- fifo_rd_en  out  1  FIFO read strobe.
- out_data  out  16  stream data.
- out_valid  out  1  stream valid.
- out_ready  in  1  stream ready.
- out_sof  out  1  high with the header word.
- out_eof  out  1  high with the last payload/pad word.
- busy  out  1  state != IDLE.
- ovf_sticky  out  1  FIFO-full seen since last clr_ovf.
- frame_count  out  16  completed frames, wraps at 0xFFFF→0.

Behaviour:
- Reset (rst=0, async): state IDLE, all outputs 0, buffer empty, in-flight flag 0, seq=0, counters and flags 0.
- Handshake: a transfer occurs when out_valid & out_ready. While out_valid is high, out_data, out_sof and out_eof are held stable until the transfer.
- Prefetch: run = enable | busy.
  - fifo_rd_en = run & ~fifo_empty & (occ + inflight < 2).
  - inflight = fifo_rd_en registered. fifo_dout is pushed into the buffer the cycle after fifo_rd_en.
  - Push and pop may occur in the same cycle. occ must never exceed 2.
- IDLE → HDR when enable & occ>0.
- HDR:
  - out_valid=1, out_sof=1, out_data={4'hA, frame_ovf, 3'b000, seq}.
  - frame_ovf is registered at entry to HDR and held constant while in HDR.
  - On transfer: → PAYLOAD, word_cnt=0.
- PAYLOAD:
  - out_valid = occ>0; out_data = buffer head.
  - out_eof = (word_cnt == FRAME_WORDS-1).
  - Each transfer pops the buffer and increments word_cnt.
  - On the eof transfer: seq++, frame_count++, clear flush_pending, → IDLE.
- Starve timer: counts cycles in PAYLOAD with occ==0; resets to 0 on any transfer. → PAD when (flush_pending | timer==TIMEOUT with TIMEOUT≠0) and occ==0.
- PAD:
  - out_valid=1, out_data=16'h0000, buffer not popped.
  - Continues word_cnt to FRAME_WORDS-1; eof rules as in PAYLOAD.
  - On eof transfer: seq++, frame_count++, clear flush_pending, → IDLE.
- flush:
  - Pulse in HDR/PAYLOAD sets flush_pending.
  - In PAYLOAD, buffered data is sent first; padding starts only once occ==0.
  - Pulse in IDLE is ignored.
- enable low mid-frame: current frame completes (data or pad). No new frame starts afterwards.
- Overflow:
  - fifo_full=1 sets ovf_sticky and frame_ovf.
  - clr_ovf clears ovf_sticky; header transfer clears frame_ovf.
  - If set and clear occur in the same cycle, set wins.
- Reset mid-frame: frame is abandoned. In-flight and buffered words are lost. No eof is emitted.

Decomposition:
- Package fifo_readout_pkg holds:
  - state enum {IDLE, HDR, PAYLOAD, PAD};
  - HDR_TAG=4'hA;
  - PAD_WORD=16'h0000;
  - header field offsets.
- Sub-module fifo_prefetch2: 2-entry 16-bit buffer with push, pop, head, and occ[1:0]. Same clk/rst.

Test Plan:
- Reset: drive rst=0 mid-stream → all outputs 0 immediately. After release: busy=0, frame_count=0, first header 0xA000.
- Normal (FRAME_WORDS=4): FIFO preloaded with 1..8, enable=1, out_ready=1 → stream A000(sof),1,2,3,4(eof),A001(sof),5,6,7,8(eof); frame_count=2.
- Backpressure: same data, out_ready toggling 1,0,1,0 → identical sequence, no drop or duplicate, occ≤2 throughout, data stable while valid & ~ready.
- Flush (FRAME_WORDS=4): FIFO holds 1,2 then empty; flush pulse after word 2 → A000,1,2,0000,0000(eof); next flush while IDLE → no output.
- Timeout (TIMEOUT=8, FRAME_WORDS=4): FIFO holds 1 word → A000,1; after 8 starved cycles → 0000,0000,0000(eof).
- Overflow: pulse fifo_full in IDLE → ovf_sticky=1, next header 0xA800. clr_ovf coincident with another fifo_full → ovf_sticky stays 1; following header without new full → 0xA001.
